// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the single-port SRAM arbiter.
// Request codes, FSM state encoding and wait counter width.
package mem_defs;

    localparam int WAIT_W = 4;

    localparam logic [1:0] MEMRW_NONE  = 2'b00;
    localparam logic [1:0] MEMRW_READ  = 2'b01;
    localparam logic [1:0] MEMRW_WRITE = 2'b10;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRD     = 3'd1;
    localparam logic [2:0] S_IRD     = 3'd2;
    localparam logic [2:0] S_WSETUP  = 3'd3;
    localparam logic [2:0] S_WSTROBE = 3'd4;
    localparam logic [2:0] S_WHOLD   = 3'd5;
    localparam logic [2:0] S_TURN    = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        DRD     = S_DRD,
        IRD     = S_IRD,
        WSETUP  = S_WSETUP,
        WSTROBE = S_WSTROBE,
        WHOLD   = S_WHOLD,
        TURN    = S_TURN
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request/response and SRAM pin bundle for mem_arbiter.
// slave is the arbiter's view, master the environment's view.
interface mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic [1:0]        mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stallreq_if;
    logic              stallreq_mem;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_data_oe;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;

    modport slave (
        input  if_req, if_addr, mem_rw, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
        output stallreq_if, stallreq_mem,
        output ram_addr, ram_wdata, ram_data_oe,
        output ram_ce_n, ram_oe_n, ram_we_n
    );

    modport master (
        output if_req, if_addr, mem_rw, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
        input  stallreq_if, stallreq_mem,
        input  ram_addr, ram_wdata, ram_data_oe,
        input  ram_ce_n, ram_oe_n, ram_we_n
    );

endinterface

// File: rtl/mem_arbiter_wait_cnt.sv
// Loadable down-counter timing the read and write strobe phases.
// Holds at zero; zero marks the final strobe cycle.
module mem_wait_cnt
    import mem_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [WAIT_W-1:0] load_val,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: data access beats fetch, strobes are
// registered from the next state so pins change cleanly on the edge.
module mem_arbiter
    import mem_defs::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_zero;
    logic              dread;
    logic              dwrite;
    logic              accept;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] rd_sample;

    assign dread     = (bus.mem_rw == MEMRW_READ);
    assign dwrite    = (bus.mem_rw == MEMRW_WRITE);
    assign accept    = (state == IDLE) && (state_nxt != IDLE);
    assign acc_addr  = (dread || dwrite) ? bus.mem_addr : bus.if_addr;
    assign rd_sample = bus.ram_rdata;

    mem_wait_cnt u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (WAIT_LD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (dread) begin
                    state_nxt = DRD;
                    cnt_load  = 1'b1;
                end else if (dwrite) begin
                    state_nxt = WSETUP;
                end else if (bus.if_req) begin
                    state_nxt = IRD;
                    cnt_load  = 1'b1;
                end
            end
            DRD, IRD: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_nxt = TURN;
            end
            WSETUP: begin
                state_nxt = WSTROBE;
                cnt_load  = 1'b1;
            end
            WSTROBE: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_nxt = WHOLD;
            end
            WHOLD:   state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ram_ce_n    <= 1'b1;
            bus.ram_oe_n    <= 1'b1;
            bus.ram_we_n    <= 1'b1;
            bus.ram_data_oe <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_wdata   <= '0;
            bus.if_rdata    <= '0;
            bus.mem_rdata   <= '0;
            bus.if_ready    <= 1'b0;
            bus.mem_ready   <= 1'b0;
        end else begin
            bus.ram_ce_n <= !(state_nxt inside
                {DRD, IRD, WSETUP, WSTROBE, WHOLD});
            bus.ram_oe_n    <= !(state_nxt inside {DRD, IRD});
            bus.ram_we_n    <= (state_nxt != WSTROBE);
            bus.ram_data_oe <= (state_nxt inside {WSETUP, WSTROBE, WHOLD});
            bus.if_ready    <= (state == IRD) && (state_nxt == TURN);
            bus.mem_ready   <= (state != IRD) && (state_nxt == TURN);
            if (accept) bus.ram_addr <= acc_addr;
            if (accept && dwrite) bus.ram_wdata <= bus.mem_wdata;
            // last strobe cycle: SRAM output is settled at this edge
            if (state == DRD && cnt_zero) bus.mem_rdata <= rd_sample;
            if (state == IRD && cnt_zero) bus.if_rdata  <= rd_sample;
        end
    end

    assign bus.stallreq_if  = bus.if_req && !bus.if_ready;
    assign bus.stallreq_mem = (dread || dwrite) && !bus.mem_ready;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port SRAM arbiter and sequencer for the 16-bit pipelined CPU.
- Shares one external SRAM between instruction fetch (IF) and the data access issued by the exe stage (memrw/memaddr/wdata).
- Generates the SRAM strobes with configurable wait states.
- Raises stall requests to the pipeline controller until each access completes.

Parameters:
WAIT_CYCLES, 1, extra strobe cycles per access beyond the first (0..15)
DATA_W, 16, data width
ADDR_W, 16, address width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request, level, held until if_ready
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction
if_ready  out  1  fetch complete, one-cycle pulse
mem_rw  in  2  data access: 00 none, 01 read, 10 write, 11 treated as none
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  write data
mem_rdata  out  DATA_W  read data
mem_ready  out  1  data access complete, one-cycle pulse
stallreq_if  out  1  if_req && !if_ready (combinational)
stallreq_mem  out  1  (mem_rw==01 || mem_rw==10) && !mem_ready (combinational)
ram_addr  out  ADDR_W  SRAM address
ram_wdata  out  DATA_W  SRAM write data
ram_rdata  in  DATA_W  SRAM read data
ram_data_oe  out  1  top-level tristate drive enable for ram_wdata
ram_ce_n  out  1  chip enable, active-low
ram_oe_n  out  1  output enable, active-low
ram_we_n  out  1  write enable, active-low

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE immediately, including mid-access.
  - ram_ce_n, ram_oe_n and ram_we_n are 1; ram_data_oe is 0.
  - ram_addr, ram_wdata, if_rdata and mem_rdata are 0; if_ready and mem_ready are 0.
- All SRAM outputs are registered; stallreq_* are the only combinational outputs.
- States: IDLE, DRD, IRD, WSETUP, WSTROBE, WHOLD, TURN.
- IDLE arbitration, fixed priority, data over fetch:
  - mem_rw=01 -> DRD
  - mem_rw=10 -> WSETUP
  - else if_req -> IRD
  - else stay in IDLE.
- Address and write data are latched on acceptance; later input changes are ignored until TURN.
- DRD / IRD:
  - ce_n=0, oe_n=0 for WAIT_CYCLES+1 cycles.
  - ram_rdata is sampled at the final cycle's edge into mem_rdata or if_rdata.
- WSETUP: 1 cycle; ce_n=0, ram_data_oe=1, address and data valid, we_n=1.
- WSTROBE: we_n=0 for WAIT_CYCLES+1 cycles.
- WHOLD: 1 cycle; we_n=1, data still driven.
- TURN: 1 cycle.
  - Bus released: ce_n=1, oe_n=1, ram_data_oe=0.
  - The matching ready output is 1, and read data is valid.
  - Requests are ignored in this cycle.
  - Next state is IDLE.
- Latency, request first seen in IDLE at cycle 0:
  - Read: ready in cycle WAIT_CYCLES+2.
  - Write: ready in cycle WAIT_CYCLES+4.
- Read data registers hold their value until the next read of the same type.
- Requester contract: the requester keeps the request asserted until ready. A request dropped mid-access does not abort the access; it completes and ready still pulses.
- Simultaneous data and fetch requests: data is served first, then fetch. Fetch starvation under back-to-back data accesses is accepted because the pipeline stalls IF during a MEM stall.
- mem_rw=11 is treated as none and gives stallreq_mem=0.
- The wait counter is 4 bits and counts down to 0. WAIT_CYCLES=0 gives single-cycle strobes.

Decomposition:
- Package mem_defs:
  - MEMRW_NONE=2'b00, MEMRW_READ=2'b01, MEMRW_WRITE=2'b10
  - State encoding localparams (3-bit)
  - WAIT_W=4
- Sub-module mem_wait_cnt: loadable 4-bit down-counter with load, en and zero outputs, used by both the read and strobe states.

Test Plan:
- WAIT_CYCLES=1, reset, then if_req=1, if_addr=16'h0010, ram_rdata=16'h1234:
  - ce_n/oe_n low in cycles 1-2.
  - if_ready=1 and if_rdata=16'h1234 in cycle 3.
  - stallreq_if high in cycles 0-2.
- mem_rw=10, mem_addr=16'h8000, mem_wdata=16'hBEEF:
  - WSETUP in cycle 1, we_n low in cycles 2-3, WHOLD in cycle 4.
  - mem_ready in cycle 5.
  - ram_data_oe=1 in cycles 1-4 only.
- if_req=1 and mem_rw=01 in the same cycle:
  - Data read completes first, with mem_ready in cycle 3.
  - Fetch starts in cycle 5 (after IDLE in cycle 4); if_ready in cycle 7.
- rst pulsed low during WSTROBE:
  - we_n, ce_n and oe_n return to 1 with no clock edge.
  - No ready pulse; state is IDLE after release.
- mem_rw=11 with if_req=0: stays in IDLE, all strobes stay 1, stallreq_mem=0.
- WAIT_CYCLES=0, back-to-back fetches at 16'h0000 and 16'h0001: if_ready pulses every 3 cycles.
